delay_timer_arbiter: RTL
========================

Name: delay_timer_arbiter

Overview:
Shares one delay counter among NREQ requesters. Each requester asks for a delay of a programmable length. The block grants the counter round-robin, counts the requested delay, then returns a one-cycle done pulse to the granted requester. It sits in front of the delay datapath so several controllers can time intervals without each owning a counter.

Parameters:
NREQ, 4, number of requesters (2..8)
CBITS, 15, counter and delay-value width in bits
ID_BITS, 2, width of grant_id; must be >= clog2(NREQ)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
req  input  NREQ  level request per requester; held high until done or abandoned
req_delay  input  NREQ*CBITS  delay value per requester; slice i is bits [i*CBITS +: CBITS]
gnt  output  NREQ  one-hot grant; high while the counter serves that requester
done  output  NREQ  one-cycle completion pulse to the served requester
busy  output  1  high whenever state != IDLE
grant_id  output  ID_BITS  index of current or last-served requester
cnt  output  CBITS  live counter value, for observation

Behaviour:
- States: IDLE, COUNT, DONE. All registers reset asynchronously on rst=1.
- Reset values: state=IDLE, cnt=0, gnt=0, done=0, busy=0, grant_id=0, rr pointer = NREQ-1, so requester 0 has highest priority first.
- IDLE, cycle t with req!=0:
  - Select the first set req bit searching from (pointer+1) mod NREQ upward with wrap.
  - At edge t+1: state=COUNT, gnt=onehot(sel), grant_id=sel, cnt=req_delay[sel].
  - The delay is sampled only at this edge. Later changes to req_delay are ignored.
- IDLE with req==0: hold state, cnt, and grant_id.
- COUNT:
  - If req[grant_id]=0, abandon: next state IDLE, gnt=0, no done pulse, pointer=grant_id.
  - Else if cnt==0: next state DONE, gnt=0, done=onehot(grant_id), pointer=grant_id.
  - Else cnt=cnt-1.
  - Abandon takes priority over completion when both apply in the same cycle.
- DONE: lasts exactly one cycle, then returns to IDLE with done=0. Arbitration resumes in that IDLE cycle.
- Latency: a request granted at edge t+1 with delay D produces done high during the cycle after edge t+D+2.
  - D=0 gives done 2 cycles after the request is seen.
  - D=2^CBITS-1 is legal; no wrap occurs because the counter only decrements to 0.
- Counter arithmetic is unsigned CBITS. cnt never increments and never underflows past 0.
- Fairness: a requester still holding req after its own done ranks last among the current requesters.
- Invariants, checked as assertions:
  - gnt is zero or one-hot; done is zero or one-hot.
  - done and gnt are never both nonzero in the same cycle.
  - done is never high two cycles in a row.
  - gnt!=0 implies state=COUNT.
  - busy = (state!=IDLE).
- Reset mid-COUNT: outputs drop immediately (asynchronous) to reset values. No done is issued for the interrupted request.
- A req bit rising during COUNT or DONE is only considered at the next IDLE.

Test Plan:
- Reset then req=0001, delay0=3 → gnt=0001 the cycle after req is seen; cnt shows 3,2,1,0; done=0001 exactly one cycle; busy falls the cycle after done.
- req=1111 held, all delays=0 → grants in order 0,1,2,3,0; each done exactly one cycle; never two gnt bits set.
- Requester 2 grant with delay 10; drop req[2] while cnt=5 → next cycle state IDLE, gnt=0, no done pulse; requester 3 is served next if pending.
- req=0101, delay0=2^15-1 → done for requester 0 after 32769 cycles; then requester 2 is granted; cnt never exceeds the loaded value.
- Assert rst while cnt=7 with gnt=0010 → gnt, done, busy, cnt all 0 in the same cycle; after release, req=0010 is served with priority restarting from requester 0.
- Change req_delay[0] from 4 to 9 during COUNT → completion still occurs after the originally sampled 4.

Source files
------------

// File: rtl/delay_timer_arbiter_if.sv
// Request/grant bundle between requesters and the shared delay timer.
// Requesters hold req until done (or drop it to abandon); the timer owns every output.
interface delay_timer_arbiter_if #(
  parameter int NREQ    = 4,
  parameter int CBITS   = 15,
  parameter int ID_BITS = 2
);
  logic [NREQ-1:0]       req;
  logic [NREQ*CBITS-1:0] req_delay;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       done;
  logic                  busy;
  logic [ID_BITS-1:0]    grant_id;
  logic [CBITS-1:0]      cnt;

  modport master (
    output req, req_delay,
    input  gnt, done, busy, grant_id, cnt
  );

  modport slave (
    input  req, req_delay,
    output gnt, done, busy, grant_id, cnt
  );
endinterface

// File: rtl/delay_timer_arbiter.sv
// Round-robin shared delay counter: grant at edge t+1, done pulse after edge t+D+2.
// Requesters wait by holding req; dropping req mid-count abandons the slot with no done.
module delay_timer_arbiter #(
  parameter int NREQ    = 4,
  parameter int CBITS   = 15,
  parameter int ID_BITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  delay_timer_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_COUNT, S_DONE} state_t;

  state_t                         r_state;
  state_t                         w_state_nxt;
  logic [CBITS-1:0]               r_cnt, w_cnt_nxt;
  logic [NREQ-1:0]                r_gnt, w_gnt_nxt;
  logic [NREQ-1:0]                r_done, w_done_nxt;
  logic [ID_BITS-1:0]             r_gid, w_gid_nxt;
  logic [ID_BITS-1:0]             r_ptr, w_ptr_nxt;
  logic [ID_BITS-1:0]             w_sel;
  logic                           w_sel_vld;
  logic [NREQ-1:0][CBITS-1:0]     w_dly;

  assign w_dly = bus.req_delay;

  // Search starts just past the last served requester so it ranks last.
  always_comb begin
    w_sel     = '0;
    w_sel_vld = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      int                 w_idx;
      logic [ID_BITS-1:0] w_cand;
      w_idx = int'(r_ptr) + k;
      if (w_idx >= NREQ) w_idx = w_idx - NREQ;
      w_cand = ID_BITS'(w_idx);
      if (!w_sel_vld && bus.req[w_cand]) begin
        w_sel     = w_cand;
        w_sel_vld = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_gnt_nxt   = r_gnt;
    w_done_nxt  = '0;
    w_gid_nxt   = r_gid;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      S_IDLE: begin
        if (w_sel_vld) begin
          w_state_nxt = S_COUNT;
          w_gnt_nxt   = NREQ'(1) << w_sel;
          w_gid_nxt   = w_sel;
          w_cnt_nxt   = w_dly[w_sel];
        end
      end
      S_COUNT: begin
        // Abandon wins over completion when both happen together.
        if (!bus.req[r_gid]) begin
          w_state_nxt = S_IDLE;
          w_gnt_nxt   = '0;
          w_ptr_nxt   = r_gid;
        end else if (r_cnt == '0) begin
          w_state_nxt = S_DONE;
          w_gnt_nxt   = '0;
          w_done_nxt  = NREQ'(1) << r_gid;
          w_ptr_nxt   = r_gid;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_gnt   <= '0;
      r_done  <= '0;
      r_gid   <= '0;
      r_ptr   <= ID_BITS'(NREQ - 1);
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_gnt   <= w_gnt_nxt;
      r_done  <= w_done_nxt;
      r_gid   <= w_gid_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  assign bus.gnt      = r_gnt;
  assign bus.done     = r_done;
  assign bus.busy     = (r_state != S_IDLE);
  assign bus.grant_id = r_gid;
  assign bus.cnt      = r_cnt;

  a_gnt_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(r_gnt));
  a_done_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(r_done));
  a_gnt_done_excl: assert property (@(posedge clk) disable iff (rst) !((|r_gnt) && (|r_done)));
  a_done_single: assert property (@(posedge clk) disable iff (rst) (|r_done) |=> !(|r_done));
  a_gnt_in_count: assert property (@(posedge clk) disable iff (rst) (|r_gnt) |-> (r_state == S_COUNT));

endmodule
